signalizer: RTL and testbench



---
 rtl/signalizer.sv | 60 ++++++
 tb/tb_signalizer.sv | 90 +++++++++
 2 files changed

// File: rtl/signalizer.sv
// -----------------------------------------------------------------------------
// signalizer -- CPU instruction-cycle phase sequencer
//
// Walks the datapath through a fixed four-phase loop, advancing one phase on
// every rising clock edge with no stall:
//   fetch -> decode -> exec -> rdmem -> fetch ...
// The strobes are mutually exclusive and one-hot. Other blocks use them to
// qualify their register updates.
//
// Ports
//   clk           in   system clock; all state changes on the rising edge
//   rst           in   synchronous active-high reset; forces FETCH
//   phase_decode  out  high during the decode phase
//   phase_exec    out  high during the execute phase
//   phase_rdmem   out  high during the memory-read phase
//   phase_fetch   out  high during the instruction-fetch phase
// -----------------------------------------------------------------------------
module signalizer (
  input  logic clk,
  input  logic rst,
  output logic phase_decode,
  output logic phase_exec,
  output logic phase_rdmem,
  output logic phase_fetch
);

  // Each state is one-hot. Its bit positions match the packed output view
  // {decode, exec, rdmem, fetch}, so the strobes are the register bits
  // themselves. No decode logic or input sits between the flops and the
  // outputs.
  typedef enum logic [3:0] {
    S_FETCH  = 4'b0001,
    S_DECODE = 4'b1000,
    S_EXEC   = 4'b0100,
    S_RDMEM  = 4'b0010
  } phase_e;

  phase_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic. A corrupted (non-one-hot) value falls into the default
  // arm, so the sequencer recovers to FETCH on the next edge.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_RDMEM;
      S_RDMEM:  state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  assign {phase_decode, phase_exec, phase_rdmem, phase_fetch} = state;

endmodule

// File: tb/tb_signalizer.sv
// -----------------------------------------------------------------------------
// tb_signalizer -- self-checking bench for the phase sequencer.
//
// The reference model is a phase index (0..3) in instruction-cycle order.
// Reset clears it. Otherwise it increments modulo 4 on each rising edge.
// A lookup table maps the index to the packed strobe pattern
// {decode, exec, rdmem, fetch}.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_signalizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic phase_decode, phase_exec, phase_rdmem, phase_fetch;
  logic [3:0] ph;

  int n_chk = 0;
  int n_err = 0;
  int ref_idx = 0;
  logic [3:0] exp_tab [4];

  signalizer dut (
    .clk          (clk),
    .rst          (rst),
    .phase_decode (phase_decode),
    .phase_exec   (phase_exec),
    .phase_rdmem  (phase_rdmem),
    .phase_fetch  (phase_fetch)
  );

  always #5 clk = ~clk;

  assign ph = {phase_decode, phase_exec, phase_rdmem, phase_fetch};

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply rst for one rising edge, advance the model, then check the
  // pattern and the one-hot property on the following falling edge.
  task automatic cyc(input logic r, input string tag);
    rst = r;
    @(posedge clk);
    ref_idx = r ? 0 : (ref_idx + 1) % 4;
    @(negedge clk);
    chk(tag, ph, exp_tab[ref_idx]);
    chk({tag, "_onehot"}, {3'b000, $onehot(ph)}, 4'b0001);
  endtask

  initial begin
    exp_tab[0] = 4'b0001;  // fetch
    exp_tab[1] = 4'b1000;  // decode
    exp_tab[2] = 4'b0100;  // exec
    exp_tab[3] = 4'b0010;  // rdmem

    // Reset entry, then release rst between edges.
    cyc(1'b1, "rst_entry");
    rst = 1'b0;
    #1 chk("rst_release", ph, 4'b0001);

    // Full cycle plus one.
    for (int i = 0; i < 5; i++) cyc(1'b0, "full_cycle");

    // Long reset, then the first advance.
    for (int i = 0; i < 5; i++) cyc(1'b1, "long_rst");
    cyc(1'b0, "long_rst_first");
    chk("long_rst_first_is_decode", ph, 4'b1000);

    // Reset from each phase: decode, exec, rdmem, fetch. Then restart.
    for (int p = 1; p <= 4; p++) begin
      cyc(1'b1, "mid_pre_rst");
      for (int k = 0; k < p; k++) cyc(1'b0, "mid_adv");
      chk("mid_at_phase", ph, exp_tab[p % 4]);
      cyc(1'b1, "mid_rst");
      chk("mid_rst_fetch", ph, 4'b0001);
      for (int k = 0; k < 3; k++) cyc(1'b0, "mid_restart");
    end

    // Random single-cycle reset pulses.
    for (int i = 0; i < 200; i++) cyc(($urandom_range(0, 7) == 0), "rand");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
